arbiter_word_packer: RTL and testbench
======================================

# arbiter_word_packer

Downstream stage of the four-queue round-robin FIFO arbiter. Consumes the arbiter's byte stream (8-bit data plus valid strobe, no backpressure) and packs consecutive valid bytes into 32-bit little-endian words. Completed or flushed words go into a small first-word-fall-through word buffer with a valid/ready output handshake. Words that cannot be buffered are dropped and flagged by a sticky overflow bit.

## Interface
- DEPTH, 4, word buffer entries (power of two, ≥2)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  byte strobe (arbiter `valid`)
- in_data  in  8  byte (arbiter `dout`); ignored when in_valid=0
- flush  in  1  emit partially filled word
- out_valid  out  1  buffer head holds a word
- out_ready  in  1  consumer accepts head this cycle
- out_data  out  32  head word; lane k = bits [8k+7:8k]
- out_keep  out  4  lane-valid mask of head word
- level  out  log2(DEPTH)+1  words currently buffered
- overflow  out  1  sticky: a word was dropped

## Operation
- Accumulator: 32-bit register plus 2-bit lane index `idx` (reset 0).
- in_valid=1: write in_data to lane `idx`, then `idx` += 1 (wraps 3→0).
- Push request (at most one per cycle):
  - Byte written at idx=3: push {acc with new byte, keep=4'b1111}, idx→0.
  - flush=1 and (idx>0 or in_valid): push bytes held so far plus any byte accepted this cycle, keep = lanes 0..last written (e.g. 4'b0011), idx→0, accumulator cleared.
  - flush=1, idx=0, in_valid=0: no operation.
- Unused lanes of a partial word read as 8'h00.
- Buffer: pop when out_valid && out_ready. Push is accepted if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
- Push while full and no pop: word dropped, overflow←1 (held until rst), idx and accumulator still cleared, level unchanged.
- Simultaneous push and pop: level unchanged, FIFO order kept.
- out_ready while out_valid=0: ignored.

## Timing
- Reset values: out_valid=0, out_data=0, out_keep=0, level=0, overflow=0, idx=0, accumulator=0.
- rst has priority over every input. Reset in the middle of a word discards the partial word and all buffered words.
- Latency: the completing byte or flush sampled at edge N gives out_valid=1 at N+1 when the buffer was empty.
- out_data and out_keep are driven directly from the head entry (first-word fall-through), with no extra read cycle.
- Throughput: one byte per cycle in, at most one word per cycle out. The input never stalls.
- out_data and out_keep stay stable while out_valid && !out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally. level uses one extra bit so full (==DEPTH) is distinct from empty.

## Structure
- Shared package `packer_pkg`:
  - constants BYTE_W=8, LANES=4, WORD_W=32
  - typedef `word_t` {data[31:0], keep[3:0]}
- Sub-module `word_fifo`:
  - synchronous FWFT FIFO of `word_t` with DEPTH parameter
  - push/pop/full/empty/level ports
  - top-level drop decision taken outside the FIFO
- Top level holds the accumulator, idx counter, flush/push logic and the overflow flag.

## Test plan
- Bytes 11,22,33,44 on 4 consecutive cycles, out_ready=1 → one cycle later out_data=32'h44332211, out_keep=4'hF, level returns to 0.
- Bytes AA,BB, then flush alone → out_data=32'h0000BBAA, keep=4'b0011. Then flush with in_valid=1 byte CC at idx=0 → data 32'h000000CC, keep=4'b0001.
- out_ready=0, stream 20 bytes (5 words) with DEPTH=4 → level=4, the 5th word is dropped, overflow=1. Drain yields words 1–4 in order and overflow stays 1.
- Buffer full with a push and out_ready=1 in the same cycle → no drop, overflow stays 0, level stays 4.
- in_valid toggled 1/0 (arbiter-style gaps) with bytes 01..08 → words 32'h04030201 and 32'h08070605, with no extra or dropped words.
- rst asserted after 2 bytes and 1 buffered word → next cycle out_valid=0, level=0, overflow=0. Bytes 55,66,77,88 then produce exactly 32'h88776655.

Source files
------------

// File: rtl/packer_pkg.sv
// packer_pkg: shared widths and the buffered word record for the byte-to-word packer
package packer_pkg;
  localparam int BYTE_W = 8;
  localparam int LANES = 4;
  localparam int WORD_W = 32;
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0] keep;
  } word_t;
endpackage

// File: rtl/word_fifo.sv
// word_fifo: first-word-fall-through FIFO of word_t (push/push_word in, pop/head out, full/empty/level status)
module word_fifo
  import packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  word_t                      push_word,
  input  logic                       pop,
  output word_t                      head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  word_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  assign head = mem[rd_ptr];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign level = cnt;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/arbiter_word_packer.sv
// arbiter_word_packer: packs a valid-strobed byte stream into little-endian 32-bit words and buffers them behind a valid/ready port
module arbiter_word_packer
  import packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [BYTE_W-1:0]       in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W-1:0]       out_data,
  output logic [LANES-1:0]        out_keep,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);
  logic [WORD_W-1:0] acc, acc_next;
  logic [1:0] idx;
  logic [2:0] n_bytes;
  logic [4:0] ones;
  logic push_req, pop, full, empty, push_ok;
  word_t head, push_word;
  always_comb begin
    acc_next = acc;
    if (in_valid) acc_next[{idx, 3'b000} +: BYTE_W] = in_data;
  end
  assign n_bytes = {1'b0, idx} + {2'b00, in_valid};
  assign ones = (5'd1 << n_bytes) - 5'd1;
  assign push_req = (in_valid && idx == 2'd3) || (flush && n_bytes != 3'd0);
  assign push_word = '{data: acc_next, keep: ones[LANES-1:0]};
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign push_ok = push_req && (!full || pop);
  assign out_data = out_valid ? head.data : '0;
  assign out_keep = out_valid ? head.keep : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
      overflow <= 1'b0;
    end else begin
      acc <= push_req ? '0 : acc_next;
      idx <= push_req ? 2'd0 : idx + 2'(in_valid);
      overflow <= overflow | (push_req && !push_ok);
    end
  end
  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push_ok),
    .push_word(push_word),
    .pop(pop),
    .head(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
endmodule

// File: tb/tb_arbiter_word_packer.sv
// tb_arbiter_word_packer: table vectors, corner sequences and random traffic checked against a queue model
module tb_arbiter_word_packer;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic out_valid, overflow;
  logic [31:0] out_data;
  logic [3:0] out_keep;
  logic [2:0] level;
  int tests = 0, fails = 0;
  logic [7:0] pend[$];
  logic [31:0] qd[$];
  logic [3:0] qk[$];
  logic [31:0] got[$];
  bit movf = 0;
  typedef struct {
    logic iv; logic [7:0] d; logic fl; logic rdy;
    logic ev; logic [31:0] ed; logic [3:0] ek; logic [2:0] el;
  } vec_t;
  vec_t tbl[10];

  arbiter_word_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] d, input logic fl, input logic rdy);
    bit pop, push;
    logic [31:0] w;
    int n;
    in_valid = iv; in_data = d; flush = fl; out_ready = rdy;
    if (out_valid && rdy) got.push_back(out_data);
    if (rst) begin
      pend.delete(); qd.delete(); qk.delete(); movf = 0;
    end else begin
      pop = qd.size() > 0 && rdy;
      if (iv) pend.push_back(d);
      n = pend.size();
      push = n == 4 || (fl && n > 0);
      if (pop) begin
        void'(qd.pop_front());
        void'(qk.pop_front());
      end
      if (push) begin
        w = 0;
        foreach (pend[i]) w = w | (32'(pend[i]) << (8 * i));
        pend.delete();
        if (qd.size() < DEPTH) begin
          qd.push_back(w);
          qk.push_back(4'((1 << n) - 1));
        end else movf = 1;
      end
    end
    @(posedge clk); #1;
    check("valid", 64'(out_valid), 64'(qd.size() > 0));
    if (qd.size() > 0) begin
      check("data", 64'(out_data), 64'(qd[0]));
      check("keep", 64'(out_keep), 64'(qk[0]));
    end
    check("level", 64'(level), 64'(qd.size()));
    check("overflow", 64'(overflow), 64'(movf));
  endtask

  task automatic do_reset();
    rst = 1;
    step(0, 0, 0, 0);
    rst = 0;
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_keep", 64'(out_keep), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
  endtask

  initial begin
    tbl[0] = '{1, 8'h11, 0, 1, 0, 32'h0, 4'h0, 3'd0};
    tbl[1] = '{1, 8'h22, 0, 1, 0, 32'h0, 4'h0, 3'd0};
    tbl[2] = '{1, 8'h33, 0, 1, 0, 32'h0, 4'h0, 3'd0};
    tbl[3] = '{1, 8'h44, 0, 1, 1, 32'h44332211, 4'hF, 3'd1};
    tbl[4] = '{0, 8'h00, 0, 1, 0, 32'h0, 4'h0, 3'd0};
    tbl[5] = '{1, 8'hAA, 0, 0, 0, 32'h0, 4'h0, 3'd0};
    tbl[6] = '{1, 8'hBB, 0, 0, 0, 32'h0, 4'h0, 3'd0};
    tbl[7] = '{0, 8'h00, 1, 0, 1, 32'h0000BBAA, 4'h3, 3'd1};
    tbl[8] = '{1, 8'hCC, 1, 1, 1, 32'h000000CC, 4'h1, 3'd1};
    tbl[9] = '{0, 8'h00, 1, 1, 0, 32'h0, 4'h0, 3'd0};
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      check($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].el));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].ed));
        check($sformatf("tbl%0d_keep", i), 64'(out_keep), 64'(tbl[i].ek));
      end
    end

    do_reset();
    for (int i = 0; i < 20; i++) step(1, 8'(i), 0, 0);
    check("ovf_level", 64'(level), 64'(4));
    check("ovf_flag", 64'(overflow), 64'(1));
    got.delete();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    check("ovf_drain_cnt", 64'(got.size()), 64'(4));
    for (int k = 0; k < 4 && k < got.size(); k++)
      check($sformatf("ovf_word%0d", k), 64'(got[k]),
            64'({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}));
    check("ovf_sticky", 64'(overflow), 64'(1));

    do_reset();
    for (int i = 0; i < 19; i++) step(1, 8'(i), 0, 0);
    step(1, 8'd19, 0, 1);
    check("fullpop_level", 64'(level), 64'(4));
    check("fullpop_ovf", 64'(overflow), 64'(0));

    do_reset();
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0, 1);
      step(0, 8'hEE, 0, 1);
    end
    step(0, 0, 0, 1);
    check("gap_cnt", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      check("gap_w0", 64'(got[0]), 64'(32'h04030201));
      check("gap_w1", 64'(got[1]), 64'(32'h08070605));
    end

    do_reset();
    for (int i = 0; i < 6; i++) step(1, 8'(i), 0, 0);
    rst = 1;
    step(1, 8'h99, 1, 0);
    rst = 0;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_level", 64'(level), 64'(0));
    check("midrst_ovf", 64'(overflow), 64'(0));
    step(1, 8'h55, 0, 0);
    step(1, 8'h66, 0, 0);
    step(1, 8'h77, 0, 0);
    step(1, 8'h88, 0, 0);
    check("midrst_word", 64'(out_data), 64'(32'h88776655));
    check("midrst_lvl1", 64'(level), 64'(1));

    do_reset();
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) < ((k / 500) % 2 == 0 ? 25 : 75));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
